crosswalk_controller: RTL and testbench



---
 rtl/crosswalk_controller.sv | 194 +++++++++++++++++++
 tb/tb_crosswalk_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/crosswalk_controller.sv
// Pedestrian crosswalk controller for a two-way intersection.
// Latches button requests on the north and west channels and grants a walk
// phase when that channel's vehicle green rises. It drives the walk/stop lamps
// and holds the green while pedestrians cross. A sticky fault is raised if both
// greens are ever seen high together.
module crosswalk_controller #(
    parameter int WALK_TICKS  = 7,
    parameter int FLASH_TICKS = 5,
    parameter int CNT_W       = 8
) (
    input  logic clk_50_mhz,
    input  logic reset,
    input  logic tick,
    input  logic nrth_xwalk_sig,
    input  logic west_xwalk_sig,
    input  logic grn_nrth,
    input  logic grn_west,
    output logic walk_nrth,
    output logic stop_nrth,
    output logic walk_west,
    output logic stop_west,
    output logic hold_nrth,
    output logic hold_west,
    output logic pend_nrth,
    output logic pend_west,
    output logic fault
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        WALK    = 2'd2,
        FLASH   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_TICKS);
    localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // Channel index 0 is north, index 1 is west.
    state_t           state [2];
    logic [CNT_W-1:0] cnt   [2];
    logic [1:0]       btn_q;
    logic [1:0]       grn_q;
    logic [1:0]       rereq;
    logic [1:0]       flash_ph;
    logic [1:0]       walk;
    logic [1:0]       stop;
    logic [1:0]       hold;
    logic [1:0]       pend;
    logic             fault_q;

    logic [1:0] btn;
    logic [1:0] grn;
    logic [1:0] btn_rise;
    logic [1:0] grn_rise;
    logic       conflict;

    // Rising-edge detection against the registered copies; conflict uses the live greens.
    assign btn      = {west_xwalk_sig, nrth_xwalk_sig};
    assign grn      = {grn_west, grn_nrth};
    assign btn_rise = btn & ~btn_q;
    assign grn_rise = grn & ~grn_q;
    assign conflict = grn[0] & grn[1];

    // Edge registers, sticky fault and both channel FSMs with registered lamp outputs.
    // NOTE: every register in this block uses non-blocking assignment so each
    // channel reads the pre-edge values of state, counter and flags.
    always_ff @(posedge clk_50_mhz) begin
        if (reset) begin
            btn_q    <= '0;
            grn_q    <= '0;
            rereq    <= '0;
            flash_ph <= '0;
            walk     <= '0;
            stop     <= '1;
            hold     <= '0;
            pend     <= '0;
            fault_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
        end else begin
            btn_q <= btn;
            grn_q <= grn;
            if (conflict) begin
                fault_q <= 1'b1;
            end

            for (int i = 0; i < 2; i++) begin
                if (conflict) begin
                    // Both greens high: force lamps safe, demote active crossings to
                    // pending and keep any request already latched.
                    walk[i]     <= 1'b0;
                    stop[i]     <= 1'b1;
                    hold[i]     <= 1'b0;
                    flash_ph[i] <= 1'b0;
                    rereq[i]    <= 1'b0;
                    cnt[i]      <= '0;
                    if (state[i] != IDLE || btn_rise[i]) begin
                        state[i] <= PENDING;
                        pend[i]  <= 1'b1;
                    end else begin
                        state[i] <= IDLE;
                        pend[i]  <= 1'b0;
                    end
                end else begin
                    case (state[i])
                        IDLE: begin
                            // A green rise in the same cycle is ignored; only the request latches.
                            if (btn_rise[i]) begin
                                state[i] <= PENDING;
                                pend[i]  <= 1'b1;
                            end
                        end

                        PENDING: begin
                            // Only a fresh green grants; a tick in this cycle is not counted.
                            if (grn_rise[i]) begin
                                state[i] <= WALK;
                                cnt[i]   <= WALK_LOAD;
                                walk[i]  <= 1'b1;
                                stop[i]  <= 1'b0;
                                hold[i]  <= 1'b1;
                                pend[i]  <= 1'b0;
                                rereq[i] <= 1'b0;
                            end
                        end

                        WALK, FLASH: begin
                            if (!grn[i]) begin
                                // Green lost early: abandon the crossing at once.
                                state[i]    <= (rereq[i] || btn_rise[i]) ? PENDING : IDLE;
                                pend[i]     <= rereq[i] || btn_rise[i];
                                walk[i]     <= 1'b0;
                                stop[i]     <= 1'b1;
                                hold[i]     <= 1'b0;
                                rereq[i]    <= 1'b0;
                                flash_ph[i] <= 1'b0;
                                cnt[i]      <= '0;
                            end else begin
                                if (btn_rise[i]) begin
                                    rereq[i] <= 1'b1;
                                end
                                if (tick) begin
                                    if (cnt[i] == CNT_ONE) begin
                                        if (state[i] == WALK) begin
                                            state[i]    <= FLASH;
                                            cnt[i]      <= FLASH_LOAD;
                                            flash_ph[i] <= 1'b1;
                                            walk[i]     <= 1'b0;
                                            stop[i]     <= 1'b1;
                                        end else begin
                                            // End of flash: release the green, re-pend if asked again.
                                            state[i]    <= (rereq[i] || btn_rise[i]) ? PENDING : IDLE;
                                            pend[i]     <= rereq[i] || btn_rise[i];
                                            rereq[i]    <= 1'b0;
                                            flash_ph[i] <= 1'b0;
                                            stop[i]     <= 1'b1;
                                            hold[i]     <= 1'b0;
                                            cnt[i]      <= '0;
                                        end
                                    end else begin
                                        cnt[i] <= cnt[i] - CNT_ONE;
                                        if (state[i] == FLASH) begin
                                            flash_ph[i] <= ~flash_ph[i];
                                            stop[i]     <= ~flash_ph[i];
                                        end
                                    end
                                end
                            end
                        end

                        default: begin
                            state[i] <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign walk_nrth = walk[0];
    assign stop_nrth = stop[0];
    assign hold_nrth = hold[0];
    assign pend_nrth = pend[0];
    assign walk_west = walk[1];
    assign stop_west = stop[1];
    assign hold_west = hold[1];
    assign pend_west = pend[1];
    assign fault     = fault_q;

endmodule

// File: tb/tb_crosswalk_controller.sv
// Directed bench for crosswalk_controller with WALK_TICKS=3, FLASH_TICKS=2.
// Each vector drives the inputs for one clock and checks the registered
// outputs just after that edge. Lamp nibbles are {walk, stop, hold, pend}.
module tb_crosswalk_controller;

    localparam logic [3:0] ID = 4'b0100; // idle: stop only
    localparam logic [3:0] PD = 4'b0101; // pending: stop + pend
    localparam logic [3:0] WK = 4'b1010; // walk: walk + hold
    localparam logic [3:0] F1 = 4'b0110; // flash, stop lamp on
    localparam logic [3:0] F0 = 4'b0010; // flash, stop lamp off

    typedef struct {
        string      name;
        logic       rst;
        logic       tk;
        logic       bn;
        logic       bw;
        logic       gn;
        logic       gw;
        logic [8:0] exp;
    } vec_t;

    logic clk_50_mhz = 1'b0;
    logic reset = 1'b1;
    logic tick = 1'b0;
    logic nrth_xwalk_sig = 1'b0;
    logic west_xwalk_sig = 1'b0;
    logic grn_nrth = 1'b0;
    logic grn_west = 1'b0;
    logic walk_nrth, stop_nrth, walk_west, stop_west;
    logic hold_nrth, hold_west, pend_nrth, pend_west, fault;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vecs[$];

    crosswalk_controller #(
        .WALK_TICKS (3),
        .FLASH_TICKS(2),
        .CNT_W      (8)
    ) dut (
        .clk_50_mhz    (clk_50_mhz),
        .reset         (reset),
        .tick          (tick),
        .nrth_xwalk_sig(nrth_xwalk_sig),
        .west_xwalk_sig(west_xwalk_sig),
        .grn_nrth      (grn_nrth),
        .grn_west      (grn_west),
        .walk_nrth     (walk_nrth),
        .stop_nrth     (stop_nrth),
        .walk_west     (walk_west),
        .stop_west     (stop_west),
        .hold_nrth     (hold_nrth),
        .hold_west     (hold_west),
        .pend_nrth     (pend_nrth),
        .pend_west     (pend_west),
        .fault         (fault)
    );

    always #10 clk_50_mhz = ~clk_50_mhz;

    function automatic vec_t mk(input string name, input logic rst, input logic tk,
                                input logic bn, input logic bw, input logic gn,
                                input logic gw, input logic [3:0] n,
                                input logic [3:0] w, input logic f);
        vec_t v;
        v.name = name;
        v.rst  = rst;
        v.tk   = tk;
        v.bn   = bn;
        v.bw   = bw;
        v.gn   = gn;
        v.gw   = gw;
        v.exp  = {n, w, f};
        return v;
    endfunction

    task automatic add(input string name, input logic rst, input logic tk,
                       input logic bn, input logic bw, input logic gn, input logic gw,
                       input logic [3:0] n, input logic [3:0] w, input logic f);
        vecs.push_back(mk(name, rst, tk, bn, bw, gn, gw, n, w, f));
    endtask

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got n=%b w=%b fault=%b, want n=%b w=%b fault=%b",
                     name, act[8:5], act[4:1], act[0], exp[8:5], exp[4:1], exp[0]);
        end
    endtask

    task automatic apply(input vec_t v);
        logic [8:0] act;
        reset          = v.rst;
        tick           = v.tk;
        nrth_xwalk_sig = v.bn;
        west_xwalk_sig = v.bw;
        grn_nrth       = v.gn;
        grn_west       = v.gw;
        @(posedge clk_50_mhz);
        #1;
        act = {walk_nrth, stop_nrth, hold_nrth, pend_nrth,
               walk_west, stop_west, hold_west, pend_west, fault};
        check(v.name, act, v.exp);
    endtask

    task automatic step(input string name, input logic rst, input logic tk,
                        input logic bn, input logic bw, input logic gn, input logic gw,
                        input logic [3:0] n, input logic [3:0] w, input logic f);
        apply(mk(name, rst, tk, bn, bw, gn, gw, n, w, f));
    endtask

    initial begin
        // Reset and quiet idle with ticks.
        add("reset", 1, 0, 0, 0, 0, 0, ID, ID, 0);
        for (int i = 0; i < 10; i++) begin
            add("idle_tick", 0, 1, 0, 0, 0, 0, ID, ID, 0);
            add("idle_gap",  0, 0, 0, 0, 0, 0, ID, ID, 0);
        end

        // North full crossing: walk for 3 ticks, flash stop 1,0, back to idle.
        add("n_press",    0, 0, 1, 0, 0, 0, PD, ID, 0);
        add("n_release",  0, 0, 0, 0, 0, 0, PD, ID, 0);
        add("n_grant",    0, 0, 0, 0, 1, 0, WK, ID, 0);
        add("n_walk_t1",  0, 1, 0, 0, 1, 0, WK, ID, 0);
        add("n_walk_gap", 0, 0, 0, 0, 1, 0, WK, ID, 0);
        add("n_walk_t2",  0, 1, 0, 0, 1, 0, WK, ID, 0);
        add("n_walk_t3",  0, 1, 0, 0, 1, 0, F1, ID, 0);
        add("n_flash_t1", 0, 1, 0, 0, 1, 0, F0, ID, 0);
        add("n_flash_gp", 0, 0, 0, 0, 1, 0, F0, ID, 0);
        add("n_flash_t2", 0, 1, 0, 0, 1, 0, ID, ID, 0);
        add("n_grn_drop", 0, 0, 0, 0, 0, 0, ID, ID, 0);

        // West pressed while its green is already high; held button makes one request.
        add("w_grn_idle", 0, 0, 0, 0, 0, 1, ID, ID, 0);
        add("w_press_gh", 0, 0, 0, 1, 0, 1, ID, PD, 0);
        add("w_held",     0, 0, 0, 1, 0, 1, ID, PD, 0);
        add("w_grn_low",  0, 0, 0, 1, 0, 0, ID, PD, 0);
        add("w_grant",    0, 0, 0, 1, 0, 1, ID, WK, 0);
        add("w_walk_t1",  0, 1, 0, 1, 0, 1, ID, WK, 0);
        add("w_walk_t2",  0, 1, 0, 1, 0, 1, ID, WK, 0);
        add("w_walk_t3",  0, 1, 0, 1, 0, 1, ID, F1, 0);
        add("w_flash_t1", 0, 1, 0, 1, 0, 1, ID, F0, 0);
        add("w_flash_t2", 0, 1, 0, 1, 0, 1, ID, ID, 0);
        add("w_held_end", 0, 0, 0, 1, 0, 1, ID, ID, 0);
        add("w_release",  0, 0, 0, 0, 0, 0, ID, ID, 0);

        foreach (vecs[i]) apply(vecs[i]);

        // Green lost during the second walk tick, first without a re-request.
        step("gl_press",   0, 0, 1, 0, 0, 0, PD, ID, 0);
        step("gl_release", 0, 0, 0, 0, 0, 0, PD, ID, 0);
        step("gl_grant",   0, 0, 0, 0, 1, 0, WK, ID, 0);
        step("gl_tick1",   0, 1, 0, 0, 1, 0, WK, ID, 0);
        step("gl_lost",    0, 1, 0, 0, 0, 0, ID, ID, 0);
        step("gl_settle",  0, 0, 0, 0, 0, 0, ID, ID, 0);
        // Then with a second press during walk: green loss returns to pending.
        step("gr_press",   0, 0, 1, 0, 0, 0, PD, ID, 0);
        step("gr_release", 0, 0, 0, 0, 0, 0, PD, ID, 0);
        step("gr_grant",   0, 0, 0, 0, 1, 0, WK, ID, 0);
        step("gr_repress", 0, 0, 1, 0, 1, 0, WK, ID, 0);
        step("gr_tick1",   0, 1, 0, 0, 1, 0, WK, ID, 0);
        step("gr_lost",    0, 0, 0, 0, 0, 0, PD, ID, 0);
        step("gr_regrant", 0, 0, 0, 0, 1, 0, WK, ID, 0);
        step("gr_lost2",   0, 0, 0, 0, 0, 0, ID, ID, 0);

        // One-cycle green conflict while north walks; fault stays set.
        step("cf_press",   0, 0, 1, 0, 0, 0, PD, ID, 0);
        step("cf_release", 0, 0, 0, 0, 0, 0, PD, ID, 0);
        step("cf_grant",   0, 0, 0, 0, 1, 0, WK, ID, 0);
        step("cf_tick1",   0, 1, 0, 0, 1, 0, WK, ID, 0);
        step("cf_both",    0, 0, 0, 0, 1, 1, PD, ID, 1);
        step("cf_resolve", 0, 0, 0, 0, 1, 0, PD, ID, 1);
        step("cf_gn_low",  0, 0, 0, 0, 0, 0, PD, ID, 1);
        step("cf_regrant", 0, 0, 0, 0, 1, 0, WK, ID, 1);
        step("cf_walk_t1", 0, 1, 0, 0, 1, 0, WK, ID, 1);
        step("cf_walk_t2", 0, 1, 0, 0, 1, 0, WK, ID, 1);
        step("cf_walk_t3", 0, 1, 0, 0, 1, 0, F1, ID, 1);
        step("cf_flash1",  0, 1, 0, 0, 1, 0, F0, ID, 1);
        step("cf_flash2",  0, 1, 0, 0, 1, 0, ID, ID, 1);

        // Reset in the middle of flash, then a normal run with a flash-time re-request.
        step("rf_gn_low",  0, 0, 0, 0, 0, 0, ID, ID, 1);
        step("rf_press",   0, 0, 1, 0, 0, 0, PD, ID, 1);
        step("rf_release", 0, 0, 0, 0, 0, 0, PD, ID, 1);
        step("rf_grant",   0, 0, 0, 0, 1, 0, WK, ID, 1);
        step("rf_walk_t1", 0, 1, 0, 0, 1, 0, WK, ID, 1);
        step("rf_walk_t2", 0, 1, 0, 0, 1, 0, WK, ID, 1);
        step("rf_walk_t3", 0, 1, 0, 0, 1, 0, F1, ID, 1);
        step("rf_reset",   1, 1, 0, 0, 1, 0, ID, ID, 0);
        step("rf_post",    0, 0, 0, 0, 1, 0, ID, ID, 0);
        step("rn_press",   0, 0, 1, 0, 1, 0, PD, ID, 0);
        step("rn_release", 0, 0, 0, 0, 1, 0, PD, ID, 0);
        step("rn_gn_low",  0, 0, 0, 0, 0, 0, PD, ID, 0);
        step("rn_grant_t", 0, 1, 0, 0, 1, 0, WK, ID, 0);
        step("rn_walk_t1", 0, 1, 0, 0, 1, 0, WK, ID, 0);
        step("rn_walk_t2", 0, 1, 0, 0, 1, 0, WK, ID, 0);
        step("rn_walk_t3", 0, 1, 0, 0, 1, 0, F1, ID, 0);
        step("rn_flash_p", 0, 0, 1, 0, 1, 0, F1, ID, 0);
        step("rn_flash1",  0, 1, 0, 0, 1, 0, F0, ID, 0);
        step("rn_flash2",  0, 1, 0, 0, 1, 0, PD, ID, 0);
        step("rn_gn_low2", 0, 0, 0, 0, 0, 0, PD, ID, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
